// File: rtl/jambu_pkg.sv
// jambu_pkg: shared tap constants, permutation round counts and FSM state type
package jambu_pkg;
    localparam int JAMBU_TAP_T1 = 15;
    localparam int JAMBU_TAP_T2 = 6;
    localparam int JAMBU_TAP_T3 = 21;
    localparam int JAMBU_TAP_T4 = 27;
    localparam int JAMBU_P640_ITERS = 20;
    localparam int JAMBU_P1024_ITERS = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} jambu_state_e;
endpackage

// File: rtl/jambu_perm_core_if.sv
// jambu_perm_core_if: request/response handshake bundle for the permutation engine
interface jambu_perm_core_if #(parameter int KEY_WORDS = 4, parameter int ITER_W = 6);
    logic                   in_valid;
    logic                   in_ready;
    logic [127:0]           in_state;
    logic [32*KEY_WORDS-1:0] in_key;
    logic [ITER_W-1:0]      in_iters;
    logic                   out_valid;
    logic                   out_ready;
    logic [127:0]           out_state;
    modport master(output in_valid, in_state, in_key, in_iters, out_ready,
                   input in_ready, out_valid, out_state);
    modport slave(input in_valid, in_state, in_key, in_iters, out_ready,
                  output in_ready, out_valid, out_state);
endinterface

// File: rtl/jambu_fsr_step.sv
// jambu_fsr_step: one 32-step TinyJAMBU NLFSR iteration built from the fsr funnel taps
module jambu_fsr_step
    import jambu_pkg::*;
(
    input  logic [127:0] state,
    input  logic [31:0]  key,
    output logic [127:0] next
);
    logic [31:0] s0, s1, s2, s3, t1, t2, t3, t4, fb;
    assign {s3, s2, s1, s0} = state;
    assign t1 = (s1 >> JAMBU_TAP_T1) | (s2 << (32 - JAMBU_TAP_T1));
    assign t2 = (s2 >> JAMBU_TAP_T2) | (s3 << (32 - JAMBU_TAP_T2));
    assign t3 = (s2 >> JAMBU_TAP_T3) | (s3 << (32 - JAMBU_TAP_T3));
    assign t4 = (s2 >> JAMBU_TAP_T4) | (s3 << (32 - JAMBU_TAP_T4));
    assign fb = s0 ^ t1 ^ ~(t2 & t3) ^ t4 ^ key;
    assign next = {fb, s3, s2, s1};
endmodule

// File: rtl/jambu_perm_core.sv
// jambu_perm_core: multi-cycle keyed TinyJAMBU permutation engine
// JAMBU_PERM_UNROLL2_EN: chain two steps per cycle while at least two iterations remain
module jambu_perm_core
    import jambu_pkg::*;
#(
    parameter int KEY_WORDS = 4,
    parameter int ITER_W    = 6
) (
    input logic clk,
    input logic rst,
    jambu_perm_core_if.slave bus
);
    localparam int IW = $clog2(KEY_WORDS);
    jambu_state_e st;
    logic [127:0] s, n1, nxt;
    logic [32*KEY_WORDS-1:0] key;
    logic [ITER_W-1:0] rem, step;
    logic [IW-1:0] idx, idx_nxt;
    logic rdy, vld;
    // Explicit wrap so non-power-of-two key lengths cycle correctly
    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return i == IW'(KEY_WORDS - 1) ? '0 : i + 1'b1;
    endfunction
    jambu_fsr_step u_s0 (.state(s), .key(key[32*int'(idx) +: 32]), .next(n1));
`ifdef JAMBU_PERM_UNROLL2_EN
    logic [127:0] n2;
    logic two;
    jambu_fsr_step u_s1 (.state(n1), .key(key[32*int'(inc(idx)) +: 32]), .next(n2));
    assign two = rem >= ITER_W'(2);
    assign nxt = two ? n2 : n1;
    assign step = two ? ITER_W'(2) : ITER_W'(1);
    assign idx_nxt = two ? inc(inc(idx)) : inc(idx);
`else
    assign nxt = n1;
    assign step = ITER_W'(1);
    assign idx_nxt = inc(idx);
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= IDLE;
            rdy <= 1'b1;
            vld <= 1'b0;
            s   <= '0;
            key <= '0;
            rem <= '0;
            idx <= '0;
        end else begin
            case (st)
                IDLE: if (bus.in_valid) begin
                    s   <= bus.in_state;
                    key <= bus.in_key;
                    rem <= bus.in_iters;
                    idx <= '0;
                    rdy <= 1'b0;
                    st  <= bus.in_iters != '0 ? RUN : DONE;
                end
                RUN: begin
                    s   <= nxt;
                    rem <= rem - step;
                    idx <= idx_nxt;
                    if (rem <= step) begin
                        st  <= DONE;
                        vld <= 1'b1;
                    end
                end
                // A zero-iteration request arrives here with vld low and spends one cycle
                DONE: if (!vld) vld <= 1'b1;
                else if (bus.out_ready) begin
                    vld <= 1'b0;
                    rdy <= 1'b1;
                    st  <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
    assign bus.in_ready = rdy;
    assign bus.out_valid = vld;
    assign bus.out_state = s;
endmodule

// File: doc/jambu_perm_core.md
Name: jambu_perm_core

Overview:
- Multi-cycle TinyJAMBU keyed-permutation engine; downstream consumer of the 64-bit funnel-shift taps (15, 6, 21, 27) produced by the JAMBU RV32 ISE datapath.
- Holds a 128-bit NLFSR state and a key, and performs one 32-step iteration per cycle (two per cycle when JAMBU_PERM_UNROLL2_EN is defined).
- Sits behind the core's ISE/co-processor port with valid/ready handshakes on both sides.

Parameters:
- KEY_WORDS, 4, number of 32-bit key words; legal values are 4, 6 and 8 (128/192/256-bit key).
- ITER_W, 6, width of the iteration-count input.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  engine idle, request accepted when in_valid & in_ready
- in_state  in  128  initial state; word s0 = [31:0] ... s3 = [127:96]
- in_key  in  32*KEY_WORDS  key; word k0 = [31:0]
- in_iters  in  ITER_W  number of 32-step iterations (P640 = 20, P1024 = 32)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_state  out  128  permuted state, same word packing as in_state

Behaviour:
- Single clock domain; asynchronous active-high reset.
- Reset values:
  - FSM state = IDLE.
  - in_ready = 1, out_valid = 0, out_state = 0.
  - Iteration counter = 0, key index = 0.
- FSM state IDLE:
  - in_ready = 1.
  - On accept, latch in_state, in_key and in_iters, and clear the key index.
  - If in_iters != 0, go to RUN; otherwise go to DONE.
- FSM state RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle performs one iteration (one jambu_fsr_step):
    - t1 = (s1>>15)|(s2<<17)
    - t2 = (s2>>6)|(s3<<26)
    - t3 = (s2>>21)|(s3<<11)
    - t4 = (s2>>27)|(s3<<5)
    - fb = s0 ^ t1 ^ ~(t2&t3) ^ t4 ^ k[idx]
    - State update: {s0,s1,s2,s3} <= {s1,s2,s3,fb}.
  - Key index increments and wraps from KEY_WORDS-1 to 0. A separate wrap counter is used, not a modulo-by-power-of-two, so KEY_WORDS = 6 works.
  - Remaining count decrements; on the last iteration go to DONE.
- FSM state DONE:
  - out_valid = 1 and out_state holds the final state, stable until accepted.
  - On out_valid & out_ready, return to IDLE (in_ready = 1 the following cycle).
  - No same-cycle bypass from DONE to a new accept.
- Latency:
  - out_valid is first high in the cycle that begins max(in_iters, 1) clock edges after the accept edge.
  - The in_iters = 0 case therefore takes 1 cycle and returns in_state unchanged.
- Boundary conditions:
  - in_iters at its maximum (2^ITER_W-1) must count correctly with no wrap.
  - Back-pressure: out_ready held low keeps DONE and out_state indefinitely.
  - Reset asserted mid-RUN or in DONE aborts immediately to the reset values; the partial state is discarded and no out_valid pulse occurs.
- All arithmetic is bitwise on 32-bit words, and all shifts are logical. The funnel forms match the ISE fsr_15/06/21/27 results with rs1 = low word and rs2 = high word.

Optional Feature:
- Macro JAMBU_PERM_UNROLL2_EN.
- When defined:
  - Two chained jambu_fsr_step instances advance two iterations per cycle while remaining >= 2, using key words idx and idx+1 with wrap.
  - When remaining == 1, a single step is taken.
  - Latency becomes ceil(in_iters/2), minimum 1.
- When undefined: one iteration per cycle, as above.
- Results are bit-identical in both builds.

Decomposition:
- Shared package jambu_pkg holds:
  - Tap constants JAMBU_TAP_T1 = 15, JAMBU_TAP_T2 = 6, JAMBU_TAP_T3 = 21, JAMBU_TAP_T4 = 27.
  - JAMBU_P640_ITERS = 20, JAMBU_P1024_ITERS = 32.
  - The FSM state enum {IDLE, RUN, DONE}.
- One natural sub-module: jambu_fsr_step, combinational, with inputs 128-bit state and 32-bit key word, output next 128-bit state.

Test Plan:
- Zero state, zero key, iters = 1 -> out_state words s0..s3 = 0, 0, 0, FFFFFFFF; out_valid 1 cycle after accept.
- Zero state, zero key, iters = 2 -> s0..s3 = 0, 0, FFFFFFFF, FC00001F; out_valid 2 cycles after accept (1 cycle with UNROLL2).
- Zero state, k0 = 00000001, iters = 1 -> s3 = FFFFFFFE; iters = 0 with any state -> out_state == in_state after 1 cycle.
- Random state/key, iters = 20 and 32, KEY_WORDS = 4 and 6 -> matches the C reference model word-for-word; in_valid pulses during RUN are ignored.
- out_ready held low 10 cycles in DONE -> out_valid and out_state stable; out_ready high -> in_ready = 1 the next cycle.
- rst asserted at iteration 7 of 32 -> out_valid = 0, in_ready = 1, out_state = 0 immediately; a fresh request afterward completes correctly.
